// File: rtl/mem_balancer_pkg.sv
// Shared definitions for the column-channel memory balancer:
// FSM state encoding, width helpers and derived sizes.
package mem_balancer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_LOAD  = 2'd1;
    localparam state_t S_RUN   = 2'd2;
    localparam state_t S_DRAIN = 2'd3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int if_width_f(
        input int nch,
        input int bw,
        input int ov
    );
        return nch * (bw - ov) + ov;
    endfunction

    function automatic int entry_width_f(
        input int bw,
        input int dw
    );
        return 2 + 2 * bw * dw;
    endfunction

endpackage

// File: rtl/mem_balancer_pair_fifo.sv
// Small FIFO holding one lane pair's entries; output reads zero when empty.
// DEPTH must be a power of two and at least 2.
module pair_fifo
    import mem_balancer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // A pop frees the slot a same-cycle push needs when full.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

    assign dout_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/mem_balancer.sv
// Splits input rows into overlapping column windows and lets an idle
// channel lane carry its partner's blocks to balance remaining work.
module mem_balancer
    import mem_balancer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int BLOCK_WIDTH  = 10,
    parameter int OVERLAP      = 2,
    parameter int BLOCK_HEIGHT = 10,
    parameter int NUM_CH       = 4,
    parameter int NUM_BLOCK_H  = 4,
    parameter int FIFO_DEPTH   = 4,
    localparam int IF_WIDTH =
        if_width_f(NUM_CH, BLOCK_WIDTH, OVERLAP),
    localparam int NPAIR = NUM_CH / 2,
    localparam int EW =
        entry_width_f(BLOCK_WIDTH, DATA_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clk_en,
    input  logic                            start,
    input  logic [NUM_CH*NUM_BLOCK_H-1:0]   valid_map,
    input  logic [IF_WIDTH*DATA_WIDTH-1:0]  col_data,
    input  logic                            col_vld,
    output logic                            col_rdy,
    output logic [NPAIR*EW-1:0]             out_data,
    output logic [NPAIR-1:0]                out_vld,
    input  logic [NPAIR-1:0]                out_rdy,
    output logic                            busy,
    output logic                            done
);

    localparam int LW   = BLOCK_WIDTH * DATA_WIDTH;
    localparam int STEP = BLOCK_WIDTH - OVERLAP;
    localparam int NV   = NUM_CH * NUM_BLOCK_H;
    localparam int RW   = clog2(NUM_BLOCK_H + 1);
    localparam int CW   = clog2(NUM_CH);
    localparam int BIW  =
        (NUM_BLOCK_H > 1) ? clog2(NUM_BLOCK_H) : 1;
    localparam int HW   =
        (BLOCK_HEIGHT > 1) ? clog2(BLOCK_HEIGHT) : 1;
    localparam logic [HW-1:0]  ROW_LAST = HW'(BLOCK_HEIGHT - 1);
    localparam logic [BIW-1:0] BLK_LAST = BIW'(NUM_BLOCK_H - 1);

    state_t            state_q, state_d;
    logic [NV-1:0]     vmap_q, vmap_d;
    logic [RW-1:0]     rem_q [NUM_CH];
    logic [RW-1:0]     rem_d [NUM_CH];
    logic [NUM_CH-1:0] help_q, help_d;
    logic [HW-1:0]     row_q, row_d;
    logic [BIW-1:0]    blk_q, blk_d;
    logic              done_q, done_d;

    logic [LW-1:0]     win      [NUM_CH];
    logic [CW-1:0]     src      [NUM_CH];
    logic [LW-1:0]     lane_dat [NUM_CH];
    logic [NUM_CH-1:0] lane_vld;
    logic [RW:0]       dec      [NUM_CH];
    logic              upd_help;
    logic              accept;
    logic [NPAIR-1:0]  push, pop, full, empty;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_win
        assign win[c] = col_data[
            (IF_WIDTH - c*STEP - BLOCK_WIDTH)*DATA_WIDTH +: LW];
    end

    // A helping lane takes its partner's window and valid bits.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            src[c] = help_q[c] ? CW'((c + NPAIR) % NUM_CH)
                               : CW'(c);
            lane_vld[c] = vmap_q[int'(src[c])*NUM_BLOCK_H
                                 + int'(blk_q)];
            lane_dat[c] = lane_vld[c] ? win[src[c]] : '0;
        end
    end

    assign col_rdy = clk_en && (state_q == S_RUN) && ~|full;
    assign accept  = col_vld && col_rdy;

    for (genvar p = 0; p < NPAIR; p++) begin : g_pair
        assign push[p] = accept &&
                         (lane_vld[p] || lane_vld[p+NPAIR]);
        assign pop[p]  = clk_en && out_rdy[p];
        assign out_vld[p] = ~empty[p];

        pair_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk),
            .rst_i   (rst),
            .push_i  (push[p]),
            .din_i   ({help_q[p], help_q[p+NPAIR],
                       lane_dat[p], lane_dat[p+NPAIR]}),
            .pop_i   (pop[p]),
            .dout_o  (out_data[p*EW +: EW]),
            .full_o  (full[p]),
            .empty_o (empty[p])
        );
    end

    always_comb begin
        state_d  = state_q;
        vmap_d   = vmap_q;
        help_d   = help_q;
        row_d    = row_q;
        blk_d    = blk_q;
        done_d   = 1'b0;
        upd_help = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            rem_d[c] = rem_q[c];
            dec[c]   = '0;
        end
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    vmap_d  = valid_map;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    rem_d[c] = '0;
                    for (int b = 0; b < NUM_BLOCK_H; b++)
                        rem_d[c] = rem_d[c] +
                            RW'(vmap_q[c*NUM_BLOCK_H + b]);
                end
                row_d    = '0;
                blk_d    = '0;
                upd_help = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (accept && row_q == ROW_LAST) begin
                    for (int l = 0; l < NUM_CH; l++)
                        if (lane_vld[l])
                            dec[src[l]] = dec[src[l]] + (RW+1)'(1);
                    for (int c = 0; c < NUM_CH; c++)
                        rem_d[c] = ({1'b0, rem_q[c]} > dec[c]) ?
                            RW'({1'b0, rem_q[c]} - dec[c]) : '0;
                    row_d    = '0;
                    blk_d    = blk_q + BIW'(1);
                    upd_help = 1'b1;
                    if (blk_q == BLK_LAST) state_d = S_DRAIN;
                end else if (accept) begin
                    row_d = row_q + HW'(1);
                end
            end
            S_DRAIN: begin
                if (~|out_vld) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Help only when the partner is at least two blocks ahead.
        if (upd_help) begin
            for (int c = 0; c < NUM_CH; c++)
                help_d[c] = ((RW+1)'(rem_d[c]) + (RW+1)'(2)) <=
                    (RW+1)'(rem_d[(c + NPAIR) % NUM_CH]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vmap_q  <= '0;
            help_q  <= '0;
            row_q   <= '0;
            blk_q   <= '0;
            done_q  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) rem_q[c] <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            vmap_q  <= vmap_d;
            help_q  <= help_d;
            row_q   <= row_d;
            blk_q   <= blk_d;
            done_q  <= done_d;
            for (int c = 0; c < NUM_CH; c++) rem_q[c] <= rem_d[c];
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_mem_balancer.sv
// Directed self-checking bench for mem_balancer with default parameters.
// Pixel values come from a row/column formula so windows are predictable.
module tb_mem_balancer;

    localparam int DW    = 8;
    localparam int BW    = 10;
    localparam int OV    = 2;
    localparam int NCH   = 4;
    localparam int NBH   = 4;
    localparam int STEP  = BW - OV;
    localparam int IFW   = NCH * STEP + OV;
    localparam int LW    = BW * DW;
    localparam int EW    = 2 + 2 * LW;
    localparam int NPAIR = NCH / 2;
    localparam int NV    = NCH * NBH;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  clk_en = 1'b1;
    logic                  start = 1'b0;
    logic [NV-1:0]         valid_map = '0;
    logic [IFW*DW-1:0]     col_data = '0;
    logic                  col_vld = 1'b0;
    logic                  col_rdy;
    logic [NPAIR*EW-1:0]   out_data;
    logic [NPAIR-1:0]      out_vld;
    logic [NPAIR-1:0]      out_rdy = '0;
    logic                  busy;
    logic                  done;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    mem_balancer dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .start     (start),
        .valid_map (valid_map),
        .col_data  (col_data),
        .col_vld   (col_vld),
        .col_rdy   (col_rdy),
        .out_data  (out_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [7:0] pix(input int r, input int k);
        return 8'((r * 7 + k * 13 + 1) & 255);
    endfunction

    function automatic logic [LW-1:0] win(input int r, input int ch);
        logic [LW-1:0] w;
        w = '0;
        for (int j = 0; j < BW; j++)
            w = {w[LW-DW-1:0], pix(r, ch * STEP + j)};
        return w;
    endfunction

    function automatic logic [IFW*DW-1:0] mk_row(input int r);
        logic [IFW*DW-1:0] v;
        v = '0;
        for (int k = 0; k < IFW; k++)
            v = {v[IFW*DW-DW-1:0], pix(r, k)};
        return v;
    endfunction

    // Source channel -1 means that lane is invalid (zero data).
    function automatic logic [EW-1:0] ent(
        input logic hl, input logic hh,
        input int sl, input int sh, input int r
    );
        logic [LW-1:0] a;
        logic [LW-1:0] b;
        a = (sl < 0) ? '0 : win(r, sl);
        b = (sh < 0) ? '0 : win(r, sh);
        return {hl, hh, a, b};
    endfunction

    task automatic start_map(input logic [NV-1:0] vm);
        valid_map = vm;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push_row(input int r);
        int n;
        n = 0;
        col_data = mk_row(r);
        col_vld = 1'b1;
        while (!col_rdy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        nchk++;
        if (col_rdy !== 1'b1) begin
            nfail++;
            $display("FAIL push_row %0d: col_rdy %b want 1", r, col_rdy);
        end else begin
            @(posedge clk); #1;
        end
        col_vld = 1'b0;
    endtask

    task automatic stream_all_valid(input int first, input int last);
        logic [EW-1:0] exp_e;
        logic [EW-1:0] got;
        for (int r = first; r <= last; r++) begin
            push_row(r);
            for (int p = 0; p < NPAIR; p++) begin
                exp_e = ent(1'b0, 1'b0, p, p + NPAIR, r);
                got = out_data[p*EW +: EW];
                nchk++;
                if (got !== exp_e) begin
                    nfail++;
                    $display("FAIL stream r%0d p%0d: got %h want %h",
                             r, p, got, exp_e);
                end
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        nchk++;
        if (done !== 1'b1) begin
            nfail++;
            $display("FAIL done_pulse: got %b want 1", done);
        end
        nchk++;
        if (busy !== 1'b0) begin
            nfail++;
            $display("FAIL idle_after_done: busy %b want 0", busy);
        end
        @(posedge clk); #1;
        nchk++;
        if (done !== 1'b0) begin
            nfail++;
            $display("FAIL done_width: got %b want 0", done);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        nchk++;
        if (col_rdy !== 1'b0) begin
            nfail++;
            $display("FAIL rst col_rdy: got %b want 0", col_rdy);
        end
        nchk++;
        if (out_vld !== 2'b00) begin
            nfail++;
            $display("FAIL rst out_vld: got %b want 00", out_vld);
        end
        nchk++;
        if (out_data !== '0) begin
            nfail++;
            $display("FAIL rst out_data: got %h want 0", out_data);
        end
        nchk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nfail++;
            $display("FAIL rst busy/done: got %b%b want 00", busy, done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        nchk++;
        if (busy !== 1'b0) begin
            nfail++;
            $display("FAIL idle_no_start: busy %b want 0", busy);
        end
    endtask

    task automatic test_all_valid();
        out_rdy = 2'b11;
        start_map(16'hFFFF);
        nchk++;
        if (busy !== 1'b1 || col_rdy !== 1'b1) begin
            nfail++;
            $display("FAIL run_entry: busy %b col_rdy %b want 11",
                     busy, col_rdy);
        end
        stream_all_valid(0, 39);
        wait_done();
    endtask

    task automatic test_help();
        logic [EW-1:0] e0;
        logic [EW-1:0] e1;
        out_rdy = 2'b11;
        start_map(16'hFFF0);
        for (int r = 0; r < 40; r++) begin
            // A start mid-map must be ignored.
            start = (r == 5);
            push_row(r);
            start = 1'b0;
            e0 = (r < 20) ? ent(1'b1, 1'b0, 2, 2, r)
                          : ent(1'b0, 1'b0, -1, 2, r);
            e1 = ent(1'b0, 1'b0, 1, 3, r);
            nchk++;
            if (out_data[0 +: EW] !== e0) begin
                nfail++;
                $display("FAIL help r%0d p0: got %h want %h",
                         r, out_data[0 +: EW], e0);
            end
            nchk++;
            if (out_data[EW +: EW] !== e1) begin
                nfail++;
                $display("FAIL help r%0d p1: got %h want %h",
                         r, out_data[EW +: EW], e1);
            end
        end
        wait_done();
    endtask

    task automatic test_backpressure();
        out_rdy = 2'b00;
        start_map(16'hFFFF);
        for (int r = 0; r < 4; r++) push_row(r);
        col_data = mk_row(4);
        col_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nchk++;
            if (col_rdy !== 1'b0 || out_vld !== 2'b11) begin
                nfail++;
                $display("FAIL full_stall: col_rdy %b out_vld %b want 0 11",
                         col_rdy, out_vld);
            end
            @(posedge clk); #1;
        end
        col_vld = 1'b0;
        out_rdy = 2'b11;
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < NPAIR; p++) begin
                nchk++;
                if (out_data[p*EW +: EW] !==
                    ent(1'b0, 1'b0, p, p + NPAIR, k)) begin
                    nfail++;
                    $display("FAIL bp_drain k%0d p%0d: got %h", k, p,
                             out_data[p*EW +: EW]);
                end
            end
            @(posedge clk); #1;
        end
        nchk++;
        if (out_vld !== 2'b00) begin
            nfail++;
            $display("FAIL bp_empty: out_vld %b want 00", out_vld);
        end
        stream_all_valid(4, 39);
        wait_done();
    endtask

    task automatic test_invalid_block();
        out_rdy = 2'b11;
        start_map(16'hDDDD);
        for (int r = 0; r < 40; r++) begin
            push_row(r);
            if (r / 10 == 1) begin
                nchk++;
                if (out_vld !== 2'b00) begin
                    nfail++;
                    $display("FAIL inv_blk r%0d: out_vld %b want 00",
                             r, out_vld);
                end
            end else begin
                for (int p = 0; p < NPAIR; p++) begin
                    nchk++;
                    if (out_data[p*EW +: EW] !==
                        ent(1'b0, 1'b0, p, p + NPAIR, r)) begin
                        nfail++;
                        $display("FAIL inv_map r%0d p%0d: got %h",
                                 r, p, out_data[p*EW +: EW]);
                    end
                end
            end
        end
        wait_done();
    endtask

    task automatic test_clk_en();
        out_rdy = 2'b00;
        start_map(16'hFFFF);
        push_row(0);
        push_row(1);
        clk_en = 1'b0;
        out_rdy = 2'b11;
        col_data = mk_row(2);
        col_vld = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            nchk++;
            if (out_vld !== 2'b11 ||
                out_data[0 +: EW] !== ent(1'b0, 1'b0, 0, 2, 0)) begin
                nfail++;
                $display("FAIL clk_en_hold: out_vld %b head %h",
                         out_vld, out_data[0 +: EW]);
            end
        end
        col_vld = 1'b0;
        clk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < NPAIR; p++) begin
                nchk++;
                if (out_data[p*EW +: EW] !==
                    ent(1'b0, 1'b0, p, p + NPAIR, k)) begin
                    nfail++;
                    $display("FAIL clk_en_resume k%0d p%0d: got %h",
                             k, p, out_data[p*EW +: EW]);
                end
            end
            @(posedge clk); #1;
        end
        nchk++;
        if (out_vld !== 2'b00) begin
            nfail++;
            $display("FAIL clk_en_extra: out_vld %b want 00", out_vld);
        end
        stream_all_valid(2, 39);
        wait_done();
    endtask

    task automatic test_reset_mid();
        out_rdy = 2'b11;
        start_map(16'hFFFF);
        stream_all_valid(0, 19);
        out_rdy = 2'b00;
        push_row(20);
        push_row(21);
        #2;
        rst = 1'b1;
        #1;
        nchk++;
        if (out_vld !== 2'b00 || out_data !== '0) begin
            nfail++;
            $display("FAIL rst_mid out: vld %b data %h want 0",
                     out_vld, out_data);
        end
        nchk++;
        if (busy !== 1'b0 || col_rdy !== 1'b0 || done !== 1'b0) begin
            nfail++;
            $display("FAIL rst_mid ctl: busy %b rdy %b done %b want 000",
                     busy, col_rdy, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_rdy = 2'b11;
        repeat (3) begin
            @(posedge clk); #1;
            nchk++;
            if (done !== 1'b0 || busy !== 1'b0 || out_vld !== 2'b00) begin
                nfail++;
                $display("FAIL rst_mid after: done %b busy %b vld %b",
                         done, busy, out_vld);
            end
        end
        start_map(16'hFFFF);
        stream_all_valid(0, 39);
        wait_done();
    endtask

    initial begin
        test_reset();
        test_all_valid();
        test_help();
        test_backpressure();
        test_invalid_block();
        test_clk_en();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
